// File: rtl/serial_word_tx_if.sv
// Parallel-word handshake plus serial bit stream between a word source and serial_word_tx.
interface serial_word_tx_if #(
    parameter int WIDTH = 12
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             bit_out;
    logic             start_out;
    logic             out_valid;
    logic             last_out;

    modport master (
        output din, din_valid,
        input  din_ready, bit_out, start_out, out_valid, last_out
    );

    modport slave (
        input  din, din_valid,
        output din_ready, bit_out, start_out, out_valid, last_out
    );
endinterface

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter, LSB first, with word-start and last-bit strobes.
// Back-to-back words are accepted on the last bit of the current word with no idle gap.
module serial_word_tx #(
    parameter int WIDTH = 12
) (
    input  logic              clk,
    input  logic              rst,
    serial_word_tx_if.slave   bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic             bit_r;
    logic             start_r;
    logic             valid_r;
    logic             last_r;
    logic             at_last;
    logic             accept;

    // Ready depends only on registered state so the source never sees a loop through din_valid.
    assign at_last       = (state == SHIFT) && (cnt == LAST_CNT);
    assign bus.din_ready = (state == IDLE) || at_last;
    assign accept        = bus.din_valid && bus.din_ready;

    assign bus.bit_out   = bit_r;
    assign bus.start_out = start_r;
    assign bus.out_valid = valid_r;
    assign bus.last_out  = last_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            bit_r   <= 1'b0;
            start_r <= 1'b0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else if (accept) begin
            state   <= SHIFT;
            shreg   <= bus.din;
            cnt     <= '0;
            bit_r   <= bus.din[0];
            start_r <= 1'b1;
            valid_r <= 1'b1;
            last_r  <= 1'b0;
        end else if ((state == SHIFT) && !at_last) begin
            // shreg[0] is already on bit_out, so the next bit to present is shreg[1].
            shreg   <= shreg >> 1;
            cnt     <= cnt + CNT_W'(1);
            bit_r   <= shreg[1];
            start_r <= 1'b0;
            valid_r <= 1'b1;
            last_r  <= (cnt == (LAST_CNT - CNT_W'(1)));
        end else begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            bit_r   <= 1'b0;
            start_r <= 1'b0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: single word, back-to-back, ignored input, async reset, invert chain, idle.
module tb_serial_word_tx;
    localparam int WIDTH = 12;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    serial_word_tx_if #(.WIDTH(WIDTH)) bus ();

    serial_word_tx #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge; all sampling and driving happens there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w);
        bus.din       = w;
        bus.din_valid = 1'b1;
        step();
        bus.din_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] got;
        rst           = 1'b1;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        step();
        step();
        got = {bus.bit_out, bus.start_out, bus.out_valid, bus.last_out, bus.din_ready};
        checks++;
        if (got !== 5'b00001) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00001", got);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_idle();
        logic [4:0] got;
        int bad;
        bad = 0;
        bus.din_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            got = {bus.bit_out, bus.start_out, bus.out_valid, bus.last_out, bus.din_ready};
            checks++;
            if (got !== 5'b00001) begin
                errors++;
                $display("FAIL idle_cycle%0d: got %b expected 00001", i, got);
            end
            step();
        end
    endtask

    task automatic test_single_word();
        logic [WIDTH-1:0] exp_bits;
        logic [4:0] got;
        logic [4:0] exp;
        exp_bits = 12'b1011_0011_0101;
        send_word(12'hB35);
        for (int i = 0; i < WIDTH; i++) begin
            got = {bus.bit_out, bus.start_out, bus.out_valid, bus.last_out, bus.din_ready};
            exp = {exp_bits[i], (i == 0), 1'b1, (i == WIDTH - 1), (i == WIDTH - 1)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL single_bit%0d {bit,start,valid,last,ready}: got %b expected %b", i, got, exp);
            end
            step();
        end
        got = {bus.bit_out, bus.start_out, bus.out_valid, bus.last_out, bus.din_ready};
        checks++;
        if (got !== 5'b00001) begin
            errors++;
            $display("FAIL single_after: got %b expected 00001", got);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] got;
        logic [4:0] exp;
        bus.din       = 12'h001;
        bus.din_valid = 1'b1;
        step();
        bus.din = 12'h800;
        for (int off = 0; off < 2 * WIDTH; off++) begin
            got = {bus.bit_out, bus.start_out, bus.out_valid, bus.last_out, bus.din_ready};
            exp = {(off == 0 || off == 23), (off == 0 || off == 12), 1'b1,
                   (off == 11 || off == 23), (off == 11 || off == 23)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL b2b_off%0d {bit,start,valid,last,ready}: got %b expected %b", off, got, exp);
            end
            if (off == 2 * WIDTH - 1) bus.din_valid = 1'b0;
            step();
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_after out_valid: got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_ignored_input();
        logic [2:0] got;
        send_word(12'h000);
        for (int i = 0; i < WIDTH; i++) begin
            if (i == 4) bus.din = 12'hFFF;
            got = {bus.bit_out, bus.out_valid, bus.start_out};
            checks++;
            if (got !== {1'b0, 1'b1, (i == 0)}) begin
                errors++;
                $display("FAIL ignored_bit%0d {bit,valid,start}: got %b expected %b", i, got, {1'b0, 1'b1, (i == 0)});
            end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            got = {bus.bit_out, bus.out_valid, bus.start_out};
            checks++;
            if (got !== 3'b000) begin
                errors++;
                $display("FAIL ignored_after%0d: got %b expected 000", i, got);
            end
            step();
        end
    endtask

    task automatic test_async_reset();
        logic [4:0] got;
        logic [WIDTH-1:0] exp_bits;
        send_word(12'hFFF);
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (bus.bit_out !== 1'b1 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre bit5 {bit,valid}: got %b%b expected 11", bus.bit_out, bus.out_valid);
        end
        #2 rst = 1'b1;
        #1;
        got = {bus.bit_out, bus.start_out, bus.out_valid, bus.last_out, bus.din_ready};
        checks++;
        if (got !== 5'b00001) begin
            errors++;
            $display("FAIL arst_immediate: got %b expected 00001", got);
        end
        step();
        rst = 1'b0;
        #2;
        checks++;
        if (bus.din_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL arst_release {ready,valid}: got %b%b expected 10", bus.din_ready, bus.out_valid);
        end
        step();
        exp_bits = 12'h003;
        send_word(12'h003);
        for (int i = 0; i < WIDTH; i++) begin
            got = {bus.bit_out, bus.start_out, bus.out_valid, bus.last_out, 1'b0};
            checks++;
            if (got !== {exp_bits[i], (i == 0), 1'b1, (i == WIDTH - 1), 1'b0}) begin
                errors++;
                $display("FAIL arst_word_bit%0d {bit,start,valid,last,0}: got %b expected %b",
                         i, got, {exp_bits[i], (i == 0), 1'b1, (i == WIDTH - 1), 1'b0});
            end
            step();
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL arst_word_after out_valid: got %b expected 0", bus.out_valid);
        end
    endtask

    // Serial two's-complement negation downstream: copy up to and including the first 1, invert after.
    task automatic test_invert_chain();
        logic [WIDTH-1:0] inv;
        logic seen_one;
        logic b;
        inv      = '0;
        seen_one = 1'b0;
        send_word(12'h005);
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.start_out) seen_one = 1'b0;
            b      = bus.bit_out;
            inv[i] = seen_one ? ~b : b;
            if (b) seen_one = 1'b1;
            step();
        end
        checks++;
        if (inv !== 12'hFFB) begin
            errors++;
            $display("FAIL invert_chain: got %h expected ffb", inv);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_idle();
        test_single_word();
        test_back_to_back();
        test_ignored_input();
        test_async_reset();
        test_invert_chain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
